// File: rtl/addn_serial.sv
// Bit-serial WIDTH-bit adder: a + b + cin computed STEP bits per clock, LSB first,
// through one STEP-bit adder, with a start/busy/done handshake.
module addn_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = STEP + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, s_q;
  logic             carry_q, cout_q, ovf_q;

  logic [STEP:0]    slice_d;
  logic [WIDTH-1:0] r_d;
  logic             cmsb_d;

  always_comb begin
    slice_d = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + SW'(carry_q);
    // Carry into the slice MSB recovered from its sum bit: c = a ^ b ^ sum.
    cmsb_d  = a_q[STEP-1] ^ b_q[STEP-1] ^ slice_d[STEP-1];
    r_d     = (r_q >> STEP) | (WIDTH'(slice_d[STEP-1:0]) << (WIDTH - STEP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> STEP;
          b_q     <= b_q >> STEP;
          r_q     <= r_d;
          carry_q <= slice_d[STEP];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= S_DONE;
            s_q     <= r_d;
            cout_q  <= slice_d[STEP];
            ovf_q   <= slice_d[STEP] ^ cmsb_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_addn_serial.sv
// Directed plus randomized bench for addn_serial: STEP=1 and STEP=4 instances
// checked against an arithmetic reference model.
module tb_addn_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start4;
  logic [15:0] a, b;
  logic        cin;
  logic        busy1, done1, cout1, ovf1;
  logic        busy4, done4, cout4, ovf4;
  logic [15:0] s1, s4;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] prev_s1 = '0;
  logic [15:0] prev_s4 = '0;

  always #5 clk = ~clk;

  addn_serial #(.WIDTH(16), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));

  addn_serial #(.WIDTH(16), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? done4 : done1;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy4 : busy1;
  endfunction
  function automatic logic [15:0] get_s(input bit sel);
    return sel ? s4 : s1;
  endfunction
  function automatic logic get_cout(input bit sel);
    return sel ? cout4 : cout1;
  endfunction
  function automatic logic get_ovf(input bit sel);
    return sel ? ovf4 : ovf1;
  endfunction

  // Reference: plain unsigned add for sum/carry, signed range test for overflow.
  task automatic model(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       output logic [15:0] es, output logic ec, output logic eo);
    logic [16:0] u;
    int          sv;
    u  = 17'(av) + 17'(bv) + 17'(ci);
    sv = int'($signed(av)) + int'($signed(bv)) + int'(ci);
    es = u[15:0];
    ec = u[16];
    eo = (sv > 32767) || (sv < -32768);
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start4 = v; else start1 = v;
  endtask

  task automatic run(input bit sel, input logic [15:0] av, input logic [15:0] bv, input logic ci);
    logic [15:0] es, hold;
    logic        ec, eo;
    int          n, lat;
    n    = sel ? 4 : 16;
    hold = sel ? prev_s4 : prev_s1;
    model(av, bv, ci, es, ec, eo);
    a = av; b = bv; cin = ci;
    set_start(sel, 1'b1);
    step();
    set_start(sel, 1'b0);
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    chk("busy_after_start", 32'(get_busy(sel)), 32'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 2) chk("s_hold_in_run", 32'(get_s(sel)), 32'(hold));
      if (get_done(sel)) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(n));
    chk("sum", 32'(get_s(sel)), 32'(es));
    chk("cout", 32'(get_cout(sel)), 32'(ec));
    chk("ovf", 32'(get_ovf(sel)), 32'(eo));
    step();
    chk("done_one_cycle", 32'(get_done(sel)), 32'd0);
    chk("idle_after_done", 32'(get_busy(sel)), 32'd0);
    chk("s_held_idle", 32'(get_s(sel)), 32'(es));
    if (sel) prev_s4 = es; else prev_s1 = es;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] es, av, bv;
    logic        ec, eo, ci;
    int          pulses, lat, n;

    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_s", 32'(s1), 32'd0);
    chk("rst_cout", 32'(cout1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_s4", 32'(s4), 32'd0);
    rst_n = 1'b1;
    step();

    run(1'b0, 16'd200, 16'd100, 1'b0);
    run(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    run(1'b0, 16'h8000, 16'h8000, 1'b1);
    run(1'b1, 16'h8000, 16'h8000, 1'b1);
    run(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    run(1'b1, 16'h7FFF, 16'h0001, 1'b0);

    // Start while busy must be ignored.
    a = 16'd1; b = 16'd1; cin = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (4) step();
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    pulses = 0; lat = 0;
    for (int i = 6; i <= 40; i++) begin
      step();
      if (done1) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    chk("ignored_start_pulses", 32'(pulses), 32'd1);
    chk("ignored_start_latency", 32'(lat), 32'd16);
    chk("ignored_start_sum", 32'(s1), 32'd2);
    prev_s1 = 16'd2;

    for (int r = 0; r < 8; r++)
      run(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    for (int r = 0; r < 8; r++)
      run(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));

    // Start held high: back-to-back operations, done every N+1 cycles.
    for (int d = 0; d < 2; d++) begin
      n = (d == 1) ? 4 : 16;
      for (int m = 0; m < 4; m++) begin
        av = 16'($urandom); bv = 16'($urandom); ci = 1'($urandom);
        a = av; b = bv; cin = ci;
        set_start(d[0], 1'b1);
        step();
        a = 16'($urandom); b = 16'($urandom);
        model(av, bv, ci, es, ec, eo);
        for (int j = 1; j <= n; j++) begin
          step();
          if (j < n) chk("b2b_no_early_done", 32'(get_done(d[0])), 32'd0);
        end
        chk("b2b_done", 32'(get_done(d[0])), 32'd1);
        chk("b2b_sum", 32'(get_s(d[0])), 32'(es));
        chk("b2b_cout", 32'(get_cout(d[0])), 32'(ec));
        chk("b2b_ovf", 32'(get_ovf(d[0])), 32'(eo));
        if (d == 1) prev_s4 = es; else prev_s1 = es;
      end
      set_start(d[0], 1'b0);
      step();
      chk("b2b_idle", 32'(get_busy(d[0])), 32'd0);
    end

    // Reset in the middle of a run aborts it.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (7) step();
    chk("midrun_busy_before", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", 32'(busy1), 32'd0);
    chk("midrun_rst_s", 32'(s1), 32'd0);
    chk("midrun_rst_done", 32'(done1), 32'd0);
    chk("midrun_rst_s4", 32'(s4), 32'd0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done1) pulses++;
    end
    chk("midrun_no_done", 32'(pulses), 32'd0);
    prev_s1 = '0;
    prev_s4 = '0;
    run(1'b0, 16'd3, 16'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
